// File: rtl/xor_serial_arbiter_if.sv
// Bundle between two operand requesters and the serial XOR arbiter.
// Handshake: a requester holds reqN_valid/a/b; the pair is taken on the edge where reqN_valid && reqN_ready.
interface xor_serial_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic             res_id;
    logic [WIDTH-1:0] res_y;
    logic             res_parity;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready, res_valid, res_id, res_y, res_parity, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready, res_valid, res_id, res_y, res_parity, busy
    );
endinterface

// File: rtl/xor_serial_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 1-bit XOR gate, bit-serially.
// Each accepted pair takes WIDTH shift cycles plus one DONE cycle that pulses res_valid.
module xor_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    xor_serial_arbiter_if.slave bus,
    output logic [1:0]          dbg_state_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic             par_q, par_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic             res_id_q, res_id_d;
    logic             res_parity_q, res_parity_d;

    logic             win0, win1, idle_ok, xfer, y_bit;
    logic [WIDTH-1:0] shifted;

    // The only XOR path for result bits: operand LSBs in, one result bit out.
    xor_gate u_xor (
        .A (a_q[0]),
        .B (b_q[0]),
        .Y (y_bit)
    );

    // On a tie the requester that did not win last time gets the slot.
    assign win0    = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    assign win1    = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    assign idle_ok = (state_q == S_IDLE) && !rst;
    assign bus.req0_ready = idle_ok && win0;
    assign bus.req1_ready = idle_ok && win1;
    assign xfer    = bus.req0_ready || bus.req1_ready;
    assign shifted = {y_bit, sh_q};

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sh_d         = sh_q;
        par_d        = par_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        res_valid_d  = 1'b0;
        res_y_d      = res_y_q;
        res_id_d     = res_id_q;
        res_parity_d = res_parity_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d      = S_SHIFT;
                    a_d          = bus.req1_ready ? bus.req1_a : bus.req0_a;
                    b_d          = bus.req1_ready ? bus.req1_b : bus.req0_b;
                    owner_d      = bus.req1_ready;
                    last_grant_d = bus.req1_ready;
                    sh_d         = '0;
                    par_d        = 1'b0;
                    cnt_d        = '0;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = shifted[WIDTH-1:1];
                par_d = par_q ^ y_bit;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the completed word so it is valid during DONE.
                if (cnt_q == LAST_BIT) begin
                    state_d      = S_DONE;
                    res_valid_d  = 1'b1;
                    res_y_d      = shifted;
                    res_id_d     = owner_q;
                    res_parity_d = par_q ^ y_bit;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sh_q         <= '0;
            par_q        <= 1'b0;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_y_q      <= '0;
            res_id_q     <= 1'b0;
            res_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_y_q      <= res_y_d;
            res_id_q     <= res_id_d;
            res_parity_q <= res_parity_d;
        end
    end

    // A reset landing in DONE abandons that result, so the pulse is masked too.
    assign bus.res_valid  = res_valid_q && !rst;
    assign bus.res_y      = res_y_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_parity = res_parity_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign dbg_state_o    = state_q;
endmodule

module xor_gate (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = A ^ B;
endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Bench for xor_serial_arbiter: WIDTH=8 and WIDTH=4 instances share one stimulus stream.
// Directed vectors and corner sequences target the 8-bit instance; a cycle model scores both.
module tb_xor_serial_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] st8, st4;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    xor_serial_arbiter_if #(.WIDTH(8)) bus8();
    xor_serial_arbiter_if #(.WIDTH(4)) bus4();

    assign bus8.req0_valid = v0;
    assign bus8.req0_a     = a0;
    assign bus8.req0_b     = b0;
    assign bus8.req1_valid = v1;
    assign bus8.req1_a     = a1;
    assign bus8.req1_b     = b1;
    assign bus4.req0_valid = v0;
    assign bus4.req0_a     = a0[3:0];
    assign bus4.req0_b     = b0[3:0];
    assign bus4.req1_valid = v1;
    assign bus4.req1_a     = a1[3:0];
    assign bus4.req1_b     = b1[3:0];

    xor_serial_arbiter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state_o(st8));
    xor_serial_arbiter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .dbg_state_o(st4));

    typedef struct {
        logic       v0;
        logic [7:0] a0, b0;
        logic       v1;
        logic [7:0] a1, b1;
        logic       eid;
        logic [7:0] ey;
        logic       epar;
    } vec_t;
    vec_t tbl[8];

    // Scoreboard entries are {id, parity, y}; one queue and model state per instance.
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    int         cnt_m[2];
    logic       lg_m[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input int w, input logic r0, input logic r1, input logic rv,
                       input logic rid, input logic rpar, input logic bsy, input logic [7:0] ry);
        logic [7:0] mask, y;
        logic       idle, e0, e1;
        logic [9:0] e;
        mask = 8'((1 << w) - 1);
        if (rst) begin
            check("ready_in_reset", 32'({r0, r1}), 32'd0);
            cnt_m[k] = 0;
            lg_m[k]  = 1'b1;
            if (k == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        idle = (cnt_m[k] == 0);
        e0 = idle && v0 && (!v1 || lg_m[k]);
        e1 = idle && v1 && (!v0 || !lg_m[k]);
        check($sformatf("ready_w%0d", w), 32'({r0, r1}), 32'({e0, e1}));
        check($sformatf("busy_w%0d", w), 32'(bsy), 32'(!idle));
        check($sformatf("res_valid_w%0d", w), 32'(rv), 32'(cnt_m[k] == 1));
        if (rv) begin
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                check($sformatf("unexpected_result_w%0d", w), 32'd1, 32'd0);
            end else begin
                if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                check($sformatf("sb_res_y_w%0d", w), 32'(ry & mask), 32'(e[7:0]));
                check($sformatf("sb_res_parity_w%0d", w), 32'(rpar), 32'(e[8]));
                check($sformatf("sb_res_id_w%0d", w), 32'(rid), 32'(e[9]));
            end
        end
        if (cnt_m[k] > 0) cnt_m[k]--;
        if (e0 || e1) begin
            y = (e1 ? (a1 ^ b1) : (a0 ^ b0)) & mask;
            if (k == 0) exp_q0.push_back({e1, ^y, y}); else exp_q1.push_back({e1, ^y, y});
            cnt_m[k] = w + 1;
            lg_m[k]  = e1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 8, bus8.req0_ready, bus8.req1_ready, bus8.res_valid, bus8.res_id,
            bus8.res_parity, bus8.busy, bus8.res_y);
        mon(1, 4, bus4.req0_ready, bus4.req1_ready, bus4.res_valid, bus4.res_id,
            bus4.res_parity, bus4.busy, {4'b0, bus4.res_y});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer8(output int id);
        id = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus8.req0_ready || bus8.req1_ready) begin
                id = bus8.req1_ready ? 1 : 0;
                return;
            end
        end
        check("xfer_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_res8(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus8.res_valid) begin
                lat = i;
                return;
            end
        end
        check("result_timeout", 32'd1, 32'd0);
    endtask

    task automatic run8(input vec_t t, input string nm);
        int id, lat;
        v0 = t.v0; a0 = t.a0; b0 = t.b0;
        v1 = t.v1; a1 = t.a1; b1 = t.b1;
        wait_xfer8(id);
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
        check({nm, "_grant"}, 32'(id), 32'(t.eid));
        wait_res8(lat);
        check({nm, "_latency"}, 32'(lat), 32'd9);
        check({nm, "_res_y"}, 32'(bus8.res_y), 32'(t.ey));
        check({nm, "_res_id"}, 32'(bus8.res_id), 32'(t.eid));
        check({nm, "_res_parity"}, 32'(bus8.res_parity), 32'(t.epar));
        tick();
    endtask

    initial begin
        int id, lat, pulses;
        tbl[0] = '{1'b1, 8'hA5, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 8'hAA, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1, 8'h01, 1'b1};
        tbl[2] = '{1'b1, 8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h80, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h0F, 1'b1, 8'hF0, 1'b0};
        tbl[4] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 1'b0, 8'h26, 1'b1};
        tbl[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hC3, 8'h5A, 1'b1, 8'h99, 1'b0};
        tbl[7] = '{1'b1, 8'h7F, 8'h00, 1'b1, 8'h11, 8'h22, 1'b0, 8'h7F, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_res_valid", 32'(bus8.res_valid), 32'd0);
        check("rst_res_y", 32'(bus8.res_y), 32'd0);
        check("rst_res_id", 32'(bus8.res_id), 32'd0);
        check("rst_res_parity", 32'(bus8.res_parity), 32'd0);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_state", 32'(st8), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run8(tbl[i], $sformatf("vec%0d", i));

        // Both requesters held valid straight out of reset: grants must alternate 0,1,0,1.
        rst = 1'b1;
        v0 = 1'b1; a0 = 8'hFF; b0 = 8'h00;
        v1 = 1'b1; a1 = 8'h3C; b1 = 8'h3C;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_xfer8(id);
            check($sformatf("rr_grant%0d", i), 32'(id), 32'(i % 2));
            wait_res8(lat);
            check($sformatf("rr_latency%0d", i), 32'(lat), 32'd9);
            check($sformatf("rr_res_y%0d", i), 32'(bus8.res_y), (i % 2 == 0) ? 32'hFF : 32'h00);
            check($sformatf("rr_res_parity%0d", i), 32'(bus8.res_parity), 32'd0);
            check($sformatf("rr_res_id%0d", i), 32'(bus8.res_id), 32'(i % 2));
        end
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
        tick();

        // Reset on the 4th shift cycle abandons the operation and clears every output.
        run8(tbl[1], "pre_reset");
        v0 = 1'b1; a0 = 8'h80; b0 = 8'h00;
        wait_xfer8(id);
        tick();
        v0 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_res_valid", 32'(bus8.res_valid), 32'd0);
        check("abort_res_y", 32'(bus8.res_y), 32'd0);
        check("abort_res_id", 32'(bus8.res_id), 32'd0);
        check("abort_res_parity", 32'(bus8.res_parity), 32'd0);
        check("abort_busy", 32'(bus8.busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.res_valid) pulses++;
        end
        check("abort_no_result", 32'(pulses), 32'd0);
        tick();
        run8(tbl[2], "post_reset");

        // A req0 valid pulse during a req1 operation must be ignored.
        v1 = 1'b1; a1 = 8'h3C; b1 = 8'hA5;
        wait_xfer8(id);
        check("pulse_grant", 32'(id), 32'd1);
        tick();
        v1 = 1'b0;
        tick();
        tick();
        v0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
        tick();
        v0 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.res_valid) begin
                pulses++;
                check("pulse_res_y", 32'(bus8.res_y), 32'h99);
                check("pulse_res_id", 32'(bus8.res_id), 32'd1);
            end
        end
        check("pulse_result_count", 32'(pulses), 32'd1);
        tick();

        // Random back-to-back traffic; the negedge model scores both widths.
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            a0 = 8'($urandom_range(0, 255));
            b0 = 8'($urandom_range(0, 255));
            a1 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (15) tick();
        check("drain_w8", 32'(exp_q0.size()), 32'd0);
        check("drain_w4", 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
